// File: rtl/instr_stream_player.sv
// Loadable, replayable AXI-Stream instruction source: buffer words, then stream them for N passes.
// Optional inter-word idle gap enabled by defining INSTR_PLAYER_GAP_EN.
module instr_stream_player #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    parameter int REP_WIDTH  = 16,
    localparam int LEN_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [USER_WIDTH-1:0] ld_user,
    input  logic                  ld_clear,
    output logic [LEN_WIDTH-1:0]  fill,
    input  logic                  start,
    input  logic [REP_WIDTH-1:0]  repeat_cnt,
    input  logic [7:0]            gap_cycles,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           words_sent,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tlast
);

    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_FULL = LEN_WIDTH'(DEPTH);
    localparam logic [REP_WIDTH-1:0] REP_ONE  = REP_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  fill_q, fill_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [REP_WIDTH-1:0]  pass_q, pass_d;
    logic [REP_WIDTH-1:0]  reps_q, reps_d;
    logic [31:0]           words_q, words_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;

    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [USER_WIDTH-1:0] mem_user_q [DEPTH];
    logic                  mem_we;

    logic                  hs;
    logic                  last_in_pass;
    logic                  last_pass;
    logic [LEN_WIDTH-1:0]  nxt_idx;

`ifdef INSTR_PLAYER_GAP_EN
    logic [7:0] gap_q, gap_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap;
    assign unused_gap = ^gap_cycles;
`endif

    assign m_axis_tvalid = (state_q == ST_PLAY);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign fill          = fill_q;
    assign words_sent    = words_q;
    assign ld_ready      = (state_q == ST_IDLE) && (fill_q < LEN_FULL);

    assign hs           = m_axis_tvalid && m_axis_tready;
    assign last_in_pass = (idx_q == fill_q - LEN_ONE);
    assign last_pass    = (pass_q == reps_q - REP_ONE);
    assign nxt_idx      = last_in_pass ? '0 : idx_q + LEN_ONE;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        reps_d  = reps_q;
        words_d = words_q;
        tdata_d = tdata_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        mem_we  = 1'b0;
`ifdef INSTR_PLAYER_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // start wins over a same-cycle load/clear so playback sees a stable fill
                if (start) begin
                    reps_d  = (repeat_cnt == '0) ? REP_ONE : repeat_cnt;
                    words_d = '0;
                    idx_d   = '0;
                    pass_d  = '0;
`ifdef INSTR_PLAYER_GAP_EN
                    gap_d   = gap_cycles;
`endif
                    if (fill_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_PLAY;
                        tdata_d = mem_data_q[0];
                        tuser_d = mem_user_q[0];
                        tlast_d = (fill_q == LEN_ONE);
                    end
                end else if (ld_clear) begin
                    fill_d = '0;
                end else if (ld_valid && ld_ready) begin
                    mem_we = 1'b1;
                    fill_d = fill_q + LEN_ONE;
                end
            end

            ST_PLAY: begin
                if (hs) begin
                    if (words_q != '1) begin
                        words_d = words_q + 32'd1;
                    end
                    if (last_in_pass && last_pass) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = nxt_idx;
                        if (last_in_pass) begin
                            pass_d = pass_q + REP_ONE;
                        end
                        tdata_d = mem_data_q[nxt_idx[IDX_WIDTH-1:0]];
                        tuser_d = mem_user_q[nxt_idx[IDX_WIDTH-1:0]];
                        tlast_d = (nxt_idx == fill_q - LEN_ONE);
`ifdef INSTR_PLAYER_GAP_EN
                        if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end
`endif
                    end
                end
            end

`ifdef INSTR_PLAYER_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == 8'd1) begin
                    state_d = ST_PLAY;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
`endif

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            reps_q  <= '0;
            words_q <= '0;
            tdata_q <= '0;
            tuser_q <= '0;
            tlast_q <= 1'b0;
`ifdef INSTR_PLAYER_GAP_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            reps_q  <= reps_d;
            words_q <= words_d;
            tdata_q <= tdata_d;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
`ifdef INSTR_PLAYER_GAP_EN
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_data_q[fill_q[IDX_WIDTH-1:0]] <= ld_data;
            mem_user_q[fill_q[IDX_WIDTH-1:0]] <= ld_user;
        end
    end

endmodule

// File: tb/tb_instr_stream_player.sv
// Randomized self-checking bench for instr_stream_player against a queue-based playback model.
module tb_instr_stream_player;

    localparam int DW    = 128;
    localparam int UW    = 1;
    localparam int DEPTH = 16;
    localparam int RW    = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic [UW-1:0] ld_user;
    logic          ld_clear;
    logic [LW-1:0] fill;
    logic          start;
    logic [RW-1:0] repeat_cnt;
    logic [7:0]    gap_cycles;
    logic          busy;
    logic          done;
    logic [31:0]   words_sent;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mdl_data[$];
    logic [UW-1:0] mdl_user[$];

    instr_stream_player #(
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .DEPTH     (DEPTH),
        .REP_WIDTH (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_user      (ld_user),
        .ld_clear     (ld_clear),
        .fill         (fill),
        .start        (start),
        .repeat_cnt   (repeat_cnt),
        .gap_cycles   (gap_cycles),
        .busy         (busy),
        .done         (done),
        .words_sent   (words_sent),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic [UW-1:0] u);
        @(negedge clk);
        check_eq("fill_during_load", fill, mdl_data.size());
        check_eq("ld_ready", ld_ready, mdl_data.size() < DEPTH);
        ld_valid = 1'b1;
        ld_clear = 1'b0;
        ld_data  = d;
        ld_user  = u;
        if (mdl_data.size() < DEPTH) begin
            mdl_data.push_back(d);
            mdl_user.push_back(u);
        end
    endtask

    task automatic clear_buf();
        @(negedge clk);
        ld_valid = 1'b0;
        ld_clear = 1'b1;
        @(negedge clk);
        ld_clear = 1'b0;
        mdl_data.delete();
        mdl_user.delete();
        check_eq("fill_after_clear", fill, 0);
    endtask

    // mode: 0 = tready held high, 1 = tready toggles, 2 = random tready
    task automatic play(input int reps_in, input int gap_in, input int mode, input bit junk);
        int  n, eff, total, k, idle, cyc, exp_gap;
        bit  counting, prev_stall, tog, r;
        n     = mdl_data.size();
        eff   = (reps_in == 0) ? 1 : reps_in;
        total = eff * n;
`ifdef INSTR_PLAYER_GAP_EN
        exp_gap = gap_in;
`else
        exp_gap = 0;
`endif
        @(negedge clk);
        ld_valid   = 1'b0;
        ld_clear   = 1'b0;
        start      = 1'b1;
        repeat_cnt = RW'(reps_in);
        gap_cycles = 8'(gap_in);
        m_axis_tready = (mode == 0);
        @(negedge clk);
        start      = 1'b0;
        repeat_cnt = RW'($urandom);
        gap_cycles = 8'($urandom);
        check_eq("busy_after_start", busy, 1);
        if (n == 0) begin
            check_eq("empty_done", done, 1);
            check_eq("empty_tvalid", m_axis_tvalid, 0);
            check_eq("empty_words_sent", words_sent, 0);
            @(negedge clk);
            check_eq("empty_busy_fall", busy, 0);
            check_eq("empty_no_tvalid", m_axis_tvalid, 0);
            check_eq("empty_done_pulse", done, 0);
            return;
        end
        check_eq("first_tvalid", m_axis_tvalid, 1);
        k = 0; idle = 0; cyc = 0; counting = 0; prev_stall = 0; tog = 1'b0;
        while (k < total && cyc < 4000) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) begin tog = ~tog; r = tog; end
            else r = ($urandom_range(0, 3) != 0);
            if (m_axis_tvalid) begin
                if (counting) begin
                    check_eq("gap_len", idle, exp_gap);
                    counting = 0;
                end
                check_eq("tdata", m_axis_tdata, mdl_data[k % n]);
                check_eq("tuser", m_axis_tuser, mdl_user[k % n]);
                check_eq("tlast", m_axis_tlast, (k % n) == (n - 1));
                m_axis_tready = r;
                if (r) begin
                    k++;
                    counting   = 1;
                    idle       = 0;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                end
            end else begin
                if (prev_stall) check_eq("tvalid_held", m_axis_tvalid, 1);
                idle++;
                m_axis_tready = r;
                prev_stall = 0;
            end
            if (junk) begin
                ld_valid = 1'($urandom);
                ld_clear = ($urandom_range(0, 3) == 0);
                start    = 1'($urandom);
                ld_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0;
        ld_clear = 1'b0;
        start    = 1'b0;
        if (k < total) begin
            check_eq("play_timeout", k, total);
            return;
        end
        check_eq("done_after_last", done, 1);
        check_eq("busy_at_done", busy, 1);
        check_eq("tvalid_at_done", m_axis_tvalid, 0);
        check_eq("words_sent", words_sent, total);
        @(negedge clk);
        check_eq("done_pulse_end", done, 0);
        check_eq("busy_fall", busy, 0);
        check_eq("fill_kept", fill, n);
        check_eq("ld_ready_idle", ld_ready, n < DEPTH);
    endtask

    initial begin
        rst = 1'b1;
        ld_valid = 1'b0; ld_data = '0; ld_user = '0; ld_clear = 1'b0;
        start = 1'b0; repeat_cnt = '0; gap_cycles = '0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_tuser", m_axis_tuser, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_fill", fill, 0);
        check_eq("rst_words_sent", words_sent, 0);
        check_eq("rst_ld_ready", ld_ready, 1);
        rst = 1'b0;

        // basic playback: 8 words, single pass, tready high
        for (int i = 0; i < 8; i++) load_word({32'h80000036, 96'(i)}, 1'b0);
        play(1, 0, 0, 0);

        // repeat with backpressure: 3 words, repeat 0 then 2
        clear_buf();
        for (int i = 0; i < 3; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        play(0, 0, 1, 0);
        play(2, 0, 1, 0);

        // full and clear
        clear_buf();
        for (int i = 0; i < DEPTH + 2; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("full_ld_ready", ld_ready, 0);
        check_eq("full_fill", fill, DEPTH);
        play(1, 0, 2, 0);
        clear_buf();
        play(1, 0, 0, 0);

        // gap: 4 words, gap 3, tready high
        for (int i = 0; i < 4; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        play(1, 3, 0, 0);

        // randomized runs with activity while busy
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 2) != 0 || mdl_data.size() == 0) begin
                int n;
                clear_buf();
                n = $urandom_range(1, DEPTH);
                for (int i = 0; i < n; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
            end
            play($urandom_range(0, 3), $urandom_range(0, 3), 2, 1);
        end

        // reset mid-stream while stalled
        clear_buf();
        for (int i = 0; i < 4; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        @(negedge clk);
        ld_valid = 1'b0;
        start = 1'b1; repeat_cnt = 16'd5; gap_cycles = 8'd0; m_axis_tready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("stall_tvalid", m_axis_tvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tvalid", m_axis_tvalid, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_fill", fill, 0);
        check_eq("async_rst_ld_ready", ld_ready, 1);
        check_eq("async_rst_words_sent", words_sent, 0);
        @(negedge clk);
        rst = 1'b0;
        mdl_data.delete();
        mdl_user.delete();
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_fill", fill, 0);
        check_eq("post_rst_ld_ready", ld_ready, 1);
        for (int i = 0; i < 2; i++) load_word({$urandom, $urandom, $urandom, $urandom}, UW'($urandom));
        play(2, 1, 2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
